// File: rtl/writeback_buffer.sv
// rtl/writeback_buffer.sv - circular writeback buffer between result producers and the register file write port
// Optional macro WB_FORWARD_EN compiles in the combinational forwarding lookup.

module writeback_buffer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_reg,
   input  logic [31:0] in_data,
   input  logic        flush,
   input  logic        wr_stall,
   output logic        reg_write,
   output logic [3:0]  wr_reg,
   output logic [31:0] wr_data,
   input  logic [3:0]  fwd_reg1,
   input  logic [3:0]  fwd_reg2,
   output logic        fwd_hit1,
   output logic        fwd_hit2,
   output logic [31:0] fwd_data1,
   output logic [31:0] fwd_data2,
   output logic [4:0]  count,
   output logic        full,
   output logic        empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [3:0]       reg_mem  [DEPTH];
   logic [31:0]      data_mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [4:0]       count_q;
   logic             push;
   logic             pop;

   // Status flags; reset forces the idle view even before the first reset edge.
   assign count    = count_q;
   assign full     = !rst && (count_q == 5'(DEPTH));
   assign empty    = rst || (count_q == 5'd0);
   assign in_ready = !full;

   // A full buffer refuses pushes even when a pop frees a slot this same cycle.
   assign push = in_valid && in_ready && !flush && !rst;

   // The head entry drives the register file whenever it is not stalled.
   assign reg_write = !empty && !wr_stall;
   assign wr_reg    = reg_write ? reg_mem[head]  : 4'd0;
   assign wr_data   = reg_write ? data_mem[head] : 32'd0;

   // Flush blocks the pop, but reg_write still shows the pre-flush head.
   assign pop = reg_write && !flush;

   // Pointer and occupancy state; reset overrides flush, which overrides push/pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         head    <= '0;
         tail    <= '0;
         count_q <= 5'd0;
      end else if (flush) begin
         head    <= '0;
         tail    <= '0;
         count_q <= 5'd0;
      end else begin
         if (push) begin
            tail <= tail + PTR_W'(1);
         end
         if (pop) begin
            head <= head + PTR_W'(1);
         end
         unique case ({push, pop})
            2'b10:   count_q <= count_q + 5'd1;
            2'b01:   count_q <= count_q - 5'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry storage needs no reset: only slots inside head..tail are ever read.
   always_ff @(posedge clk) begin
      if (push) begin
         reg_mem[tail]  <= in_reg;
         data_mem[tail] <= in_data;
      end
   end

`ifdef WB_FORWARD_EN
   logic [PTR_W-1:0] fwd_idx;

   // Walk from oldest to newest so the entry closest to tail wins a match.
   always_comb begin
      fwd_hit1  = 1'b0;
      fwd_hit2  = 1'b0;
      fwd_data1 = 32'd0;
      fwd_data2 = 32'd0;
      fwd_idx   = '0;
      for (int k = 0; k < DEPTH; k++) begin
         fwd_idx = head + PTR_W'(k);
         if (!rst && (5'(k) < count_q)) begin
            if (reg_mem[fwd_idx] == fwd_reg1) begin
               fwd_hit1  = 1'b1;
               fwd_data1 = data_mem[fwd_idx];
            end
            if (reg_mem[fwd_idx] == fwd_reg2) begin
               fwd_hit2  = 1'b1;
               fwd_data2 = data_mem[fwd_idx];
            end
         end
      end
   end
`else
   logic unused_fwd;

   assign unused_fwd = ^{fwd_reg1, fwd_reg2};
   assign fwd_hit1   = 1'b0;
   assign fwd_hit2   = 1'b0;
   assign fwd_data1  = 32'd0;
   assign fwd_data2  = 32'd0;
`endif

endmodule

// File: doc/writeback_buffer.md
WRITEBACK_BUFFER -- requirements
Module: writeback_buffer

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 4, number of pending write entries (power of two, 2..16).
REQ-002 The block SHALL have one clock, and its reset SHALL be synchronous and active-high.
REQ-003 The clock port SHALL be: clk  input  1  rising-edge clock.
REQ-004 The reset port SHALL be: rst  input  1  synchronous active-high reset.
REQ-005 The block SHALL have input port: in_valid  input  1  producer offers a result.
REQ-006 The block SHALL have output port: in_ready  output  1  buffer can accept.
REQ-007 The block SHALL have input port: in_reg  input  4  destination register index.
REQ-008 The block SHALL have input port: in_data  input  32  result value.
REQ-009 The block SHALL have input port: flush  input  1  discard all pending entries.
REQ-010 The block SHALL have input port: wr_stall  input  1  register file cannot take a write this cycle.
REQ-011 The block SHALL have output ports reg_write (1), wr_reg (4) and wr_data (32), which drive the register file write port.
REQ-012 The block SHALL have input ports fwd_reg1 and fwd_reg2 (4 each), the forwarding lookup addresses.
REQ-013 The block SHALL have output ports fwd_hit1 and fwd_hit2 (1 each) and fwd_data1 and fwd_data2 (32 each), the forwarding results.
REQ-014 The block SHALL have output ports count (5, pending entries), full (1) and empty (1).

Function
REQ-015 Storage SHALL be a circular FIFO of DEPTH entries {reg[3:0], data[31:0]} with head and tail pointers that wrap modulo DEPTH.
REQ-016 The push condition SHALL be in_valid && in_ready && !flush; the entry SHALL be written at tail at the rising edge.
REQ-017 in_ready SHALL equal !full; a push SHALL NOT be accepted while full, even when a pop occurs in the same cycle.
REQ-018 reg_write SHALL equal !empty && !wr_stall (combinational). wr_reg and wr_data SHALL equal the head entry when reg_write=1, and 0 otherwise.
REQ-019 The pop condition SHALL be reg_write && !flush; head SHALL advance at the rising edge.
REQ-020 Latency SHALL be: entry accepted at edge N into an empty buffer produces reg_write=1 in the cycle after edge N, if not stalled.
REQ-021 On simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-022 count SHALL hold values 0..DEPTH; full = (count==DEPTH); empty = (count==0).
REQ-023 Order SHALL be preserved: writes SHALL be issued in acceptance order, including repeated writes to the same register.
REQ-024 flush SHALL have priority: at the edge, count=0 and head=tail=0. A same-cycle push SHALL be discarded. reg_write still reflects the pre-flush state in the flush cycle.
REQ-025 wr_stall held high SHALL freeze head, with the buffer filling to full; pending data SHALL NOT be lost.
REQ-026 Forwarding SHALL be combinational: fwd_hitN=1 when any valid entry has reg==fwd_regN. fwd_dataN SHALL be the data of the newest such entry (closest to tail), otherwise 0.
REQ-027 The head entry SHALL remain visible to forwarding during the cycle it is popped. The in_* values of the current cycle SHALL NOT be forwarded.

Reset
REQ-028 When rst=1 at a rising edge: count=0, head=tail=0, and entry contents are don't-care.
REQ-029 While in reset and after it: reg_write=0, wr_reg=0, wr_data=0, in_ready=1, empty=1, full=0, fwd_hit1=fwd_hit2=0, fwd_data1=fwd_data2=0.
REQ-030 rst SHALL override flush, push and pop. Entries accepted mid-operation SHALL be dropped by a reset, and no write SHALL be issued for them.

Configuration
REQ-031 Macro WB_FORWARD_EN: when defined, the forwarding logic of REQ-026..027 SHALL be compiled in.
REQ-032 When WB_FORWARD_EN is undefined, the forwarding compare logic SHALL be absent. fwd_hit1/2 SHALL be tied to 0 and fwd_data1/2 tied to 0, while the ports remain present.

Verification
REQ-033 Single push, no stall: in_reg=3, in_data=0xDEADBEEF accepted at edge 1 -> reg_write=1, wr_reg=3, wr_data=0xDEADBEEF in cycle 2; empty=1 after edge 2.
REQ-034 Fill with wr_stall=1: push regs 1,2,3,4 with data 0x11..0x44 -> full=1, in_ready=0, count=4, and a 5th offer is refused. Release the stall -> four writes in order 1,2,3,4 on consecutive cycles.
REQ-035 Forwarding, WB_FORWARD_EN defined and stalled: push (5,0xA), then (5,0xB), with fwd_reg1=5, fwd_reg2=6 -> fwd_hit1=1, fwd_data1=0xB, fwd_hit2=0, fwd_data2=0.
REQ-036 Flush with 3 entries plus a concurrent push -> next cycle count=0, empty=1, reg_write=0, and no write of the concurrent entry.
REQ-037 Simultaneous push/pop at count=2 with DEPTH=4 over 10 cycles -> count stays 2, pointers wrap, and output order matches input order.
REQ-038 Reset asserted with 2 pending entries -> next cycle count=0, reg_write=0, and wr_reg=wr_data=0.
